triad_uart_tx: RTL and testbench

- Downstream consumer of the triad manager's `data_avl`/`triad_data[67:0]` output, i.e. the reader side of that interface.
- Captures each new triad word `{pulse_id_2, pulse_id_1, pulse_id_0, polynomial}` into a small FIFO.
- Serialises each word as a framed, checksummed 8N1 UART packet toward the host MCU.
- Sits between the triad manager and the board-level TX pin; decouples bursty triad results from the slow serial link.

---
 rtl/triad_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_triad_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triad_uart_tx.sv
// Triad result UART transmitter: edge-detects data_avl, queues 68-bit triad words in a
// small FIFO and sends each as an 11-byte SYNC/payload/XOR-checksum 8N1 frame.
module triad_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 96,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hAA
) (
    input  logic                        clk_96MHz,
    input  logic                        reset,
    input  logic                        data_avl,
    input  logic [67:0]                 triad_data,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  overflow_count
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   LVL_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   LVL_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [TW-1:0] TIMER_END = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          avl_q;
    logic [67:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   level_q, level_d;
    logic [7:0]    ovf_q;
    logic [71:0]   word_q;
    logic [7:0]    shift_q, csum_q, cur_byte;
    logic [3:0]    idx_q;
    logic [2:0]    bit_q;
    logic [TW-1:0] timer_q;
    logic          tx_q, busy_q;
    logic          capture, full, pop, push, drop, bit_done;

    assign capture  = data_avl & ~avl_q;
    assign full     = (level_q == LVL_FULL);
    assign pop      = (state_q == IDLE) && (level_q != '0);
    // A pop on the same edge frees the slot, so a capture into a full FIFO still fits.
    assign push     = capture && (!full || pop);
    assign drop     = capture && full && !pop;
    assign bit_done = (timer_q == TIMER_END);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_comb begin
        cur_byte = word_q[71:64];
        if (idx_q == 4'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (idx_q == 4'd10) begin
            cur_byte = csum_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            avl_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            avl_q   <= data_avl;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop && ovf_q != 8'hFF) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the cleared pointers and level make stale words unreachable.
    always_ff @(posedge clk_96MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= triad_data;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            timer_q <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            shift_q <= '0;
            csum_q  <= '0;
        end else begin
            timer_q <= bit_done ? '0 : timer_q + TIMER_ONE;
            case (state_q)
                IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    timer_q <= '0;
                    if (pop) begin
                        word_q  <= {4'b0000, mem_q[rd_ptr_q]};
                        csum_q  <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        shift_q <= cur_byte;
                        tx_q    <= cur_byte[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                        // Payload bytes feed the checksum; the hold register shifts MSB-first.
                        if (idx_q != 4'd0 && idx_q != 4'd10) begin
                            csum_q <= csum_q ^ cur_byte;
                            word_q <= {word_q[63:0], 8'h00};
                        end
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (idx_q == 4'd10) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx        = tx_q;
    assign busy           = busy_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_triad_uart_tx.sv
// Directed bench for triad_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a passive
// decoder on uart_tx recording each byte and the cycle its start bit began.
module tb_triad_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam logic [67:0] W_SINGLE = 68'h1_2345_6789_ABCD_EF01;
    localparam logic [67:0] W_ONES   = 68'hF_FFFF_FFFF_FFFF_FFFF;

    logic        clk_96MHz = 1'b0;
    logic        reset = 1'b1;
    logic        data_avl = 1'b0;
    logic [67:0] triad_data = '0;
    logic        uart_tx, busy;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] exp_single [11] = '{8'hAA, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                    8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h01};
    logic [7:0] exp_ones [11]   = '{8'hAA, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};

    triad_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hAA)) dut (
        .clk_96MHz     (clk_96MHz),
        .reset         (reset),
        .data_avl      (data_avl),
        .triad_data    (triad_data),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .overflow_count(overflow_count)
    );

    initial forever #5 clk_96MHz = ~clk_96MHz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor: samples on the falling edge, mid-bit for data and stop bits.
    logic [7:0] rx_q [$];
    int         rx_ts [$];
    int         cyc = 0, toggles = 0, framing_err = 0, max_level = 0;
    int         bcnt = 0, last_busy = 0, m_cnt = 0, m_start = 0;
    bit         m_active = 1'b0;
    logic       prev_tx = 1'b1;
    logic [7:0] m_sh = '0;

    initial forever begin
        @(negedge clk_96MHz);
        cyc++;
        if (uart_tx !== prev_tx) toggles++;
        prev_tx = uart_tx;
        if (!reset && int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (busy === 1'b1) bcnt++;
        else if (bcnt > 0) begin
            last_busy = bcnt;
            bcnt = 0;
        end
        if (reset) begin
            m_active = 1'b0;
            bcnt = 0;
        end else if (!m_active) begin
            if (uart_tx === 1'b0) begin
                m_active = 1'b1;
                m_cnt = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                if (m_cnt / CPB >= 1 && m_cnt / CPB <= 8) begin
                    m_sh[m_cnt / CPB - 1] = uart_tx;
                end else if (m_cnt / CPB == 9) begin
                    if (uart_tx === 1'b1) begin
                        rx_q.push_back(m_sh);
                        rx_ts.push_back(m_start);
                    end else begin
                        framing_err++;
                    end
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic pulse(input logic [67:0] w);
        @(posedge clk_96MHz); #1;
        data_avl = 1'b1;
        triad_data = w;
        @(posedge clk_96MHz); #1;
        data_avl = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit, input string name);
        int k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(negedge clk_96MHz);
            k++;
        end
        if (rx_q.size() < n) begin
            total_cnt++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (!(busy === 1'b0 && fifo_level === 3'd0) && k < limit) begin
            @(negedge clk_96MHz);
            k++;
        end
        if (!(busy === 1'b0 && fifo_level === 3'd0)) begin
            total_cnt++;
            $display("FAIL %s_idle_timeout: busy=%b fifo_level=%0d", name, busy, fifo_level);
        end
        repeat (4) @(negedge clk_96MHz);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_96MHz);
        #1 reset = 1'b0;
        @(negedge clk_96MHz);
        total_cnt++;
        if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", uart_tx);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d, required 0", fifo_level);
        else pass_cnt++;
        total_cnt++;
        if (overflow_count !== 8'd0) $display("FAIL reset_ovf: got %0d, required 0", overflow_count);
        else pass_cnt++;
        @(negedge clk_96MHz);
        toggles = 0;
        repeat (100) @(negedge clk_96MHz);
        total_cnt++;
        if (toggles != 0 || rx_q.size() != 0)
            $display("FAIL reset_quiet: got %0d toggles %0d bytes, required 0 0", toggles, rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_single;
        rx_q.delete();
        rx_ts.delete();
        @(posedge clk_96MHz); #1;
        data_avl = 1'b1;
        triad_data = W_SINGLE;
        @(posedge clk_96MHz); #1;
        data_avl = 1'b0;
        @(negedge clk_96MHz);
        total_cnt++;
        if (uart_tx !== 1'b1 || fifo_level !== 3'd1)
            $display("FAIL single_capture: got tx=%b level=%0d, required tx=1 level=1", uart_tx, fifo_level);
        else pass_cnt++;
        @(negedge clk_96MHz);
        total_cnt++;
        if (uart_tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 3'd0)
            $display("FAIL single_start: got tx=%b busy=%b level=%0d, required 0 1 0", uart_tx, busy, fifo_level);
        else pass_cnt++;
        wait_bytes(11, 600, "single");
        wait_idle(100, "single");
        for (int i = 0; i < 11; i++) begin
            total_cnt++;
            if (i >= rx_q.size()) $display("FAIL single_byte%0d: missing, required %h", i, exp_single[i]);
            else if (rx_q[i] !== exp_single[i])
                $display("FAIL single_byte%0d: got %h, required %h", i, rx_q[i], exp_single[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (last_busy != 11 * 10 * CPB) $display("FAIL single_busy_len: got %0d, required %0d", last_busy, 440);
        else pass_cnt++;
        total_cnt++;
        if (rx_ts.size() != 11 || rx_ts[10] - rx_ts[0] != 10 * 10 * CPB)
            $display("FAIL single_byte_spacing: got %0d bytes, required 11 bytes spanning 400 cycles", rx_ts.size());
        else pass_cnt++;
    endtask

    task automatic test_hold;
        int bad = -1;
        rx_q.delete();
        rx_ts.delete();
        max_level = 0;
        @(posedge clk_96MHz); #1;
        data_avl = 1'b1;
        triad_data = W_SINGLE;
        repeat (10) @(posedge clk_96MHz);
        #1 data_avl = 1'b0;
        wait_bytes(11, 600, "hold");
        wait_idle(100, "hold");
        repeat (50) @(negedge clk_96MHz);
        total_cnt++;
        if (rx_q.size() != 11) $display("FAIL hold_frame_count: got %0d bytes, required 11", rx_q.size());
        else pass_cnt++;
        for (int i = 0; i < 11; i++)
            if (bad < 0 && i < rx_q.size() && rx_q[i] !== exp_single[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL hold_frame: byte %0d got %h, required %h", bad, rx_q[bad], exp_single[bad]);
        else pass_cnt++;
        total_cnt++;
        if (max_level != 1) $display("FAIL hold_max_level: got %0d, required 1", max_level);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        rx_q.delete();
        rx_ts.delete();
        for (int k = 1; k <= 6; k++) pulse(68'(k));
        @(negedge clk_96MHz);
        total_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d, required 4", fifo_level);
        else pass_cnt++;
        total_cnt++;
        if (overflow_count !== 8'd1) $display("FAIL ovf_count: got %0d, required 1", overflow_count);
        else pass_cnt++;
        wait_bytes(55, 3000, "ovf");
        wait_idle(100, "ovf");
        repeat (100) @(negedge clk_96MHz);
        total_cnt++;
        if (rx_q.size() != 55) $display("FAIL ovf_byte_count: got %0d, required 55", rx_q.size());
        else pass_cnt++;
        for (int f = 0; f < 5; f++) begin
            int bad = -1;
            logic [7:0] e = '0;
            for (int i = 0; i < 11; i++) begin
                e = (i == 0) ? 8'hAA : (i >= 9) ? 8'(f + 1) : 8'h00;
                if (bad < 0 && (11 * f + i >= rx_q.size() || rx_q[11 * f + i] !== e)) bad = i;
            end
            total_cnt++;
            if (bad >= 0) $display("FAIL ovf_frame%0d: byte %0d wrong or missing, required word %0d", f, bad, f + 1);
            else pass_cnt++;
        end
        for (int f = 1; f < 5; f++) begin
            total_cnt++;
            if (rx_ts.size() < 11 * f + 1 || rx_ts[11 * f] - rx_ts[11 * (f - 1)] != 110 * CPB + 1)
                $display("FAIL ovf_gap%0d: frame start spacing wrong, required %0d", f, 110 * CPB + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_checksum;
        rx_q.delete();
        rx_ts.delete();
        pulse(W_ONES);
        wait_bytes(11, 600, "csum");
        wait_idle(100, "csum");
        for (int i = 0; i < 11; i++) begin
            total_cnt++;
            if (i >= rx_q.size()) $display("FAIL csum_byte%0d: missing, required %h", i, exp_ones[i]);
            else if (rx_q[i] !== exp_ones[i])
                $display("FAIL csum_byte%0d: got %h, required %h", i, rx_q[i], exp_ones[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        int bad = -1;
        rx_q.delete();
        rx_ts.delete();
        pulse(68'h11);
        pulse(68'h22);
        pulse(68'h33);
        @(negedge clk_96MHz);
        total_cnt++;
        if (fifo_level !== 3'd2) $display("FAIL rmid_queued: got %0d, required 2", fifo_level);
        else pass_cnt++;
        wait_bytes(4, 500, "rmid");
        repeat (20) @(posedge clk_96MHz);
        #1 reset = 1'b1;
        @(posedge clk_96MHz);
        #1 reset = 1'b0;
        @(negedge clk_96MHz);
        total_cnt++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0)
            $display("FAIL rmid_state: got tx=%b busy=%b level=%0d, required 1 0 0", uart_tx, busy, fifo_level);
        else pass_cnt++;
        @(negedge clk_96MHz);
        toggles = 0;
        repeat (600) @(negedge clk_96MHz);
        total_cnt++;
        if (toggles != 0 || rx_q.size() != 4)
            $display("FAIL rmid_quiet: got %0d toggles %0d bytes, required 0 4", toggles, rx_q.size());
        else pass_cnt++;
        rx_q.delete();
        rx_ts.delete();
        pulse(W_SINGLE);
        wait_bytes(11, 600, "rmid_after");
        wait_idle(100, "rmid_after");
        for (int i = 0; i < 11; i++)
            if (bad < 0 && (i >= rx_q.size() || rx_q[i] !== exp_single[i])) bad = i;
        total_cnt++;
        if (bad >= 0 || rx_q.size() != 11)
            $display("FAIL rmid_clean_frame: byte %0d wrong or %0d bytes, required 11 matching", bad, rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        for (int k = 1; k <= 5; k++) pulse(68'(k));
        for (int k = 0; k < 10; k++) pulse(68'h5A);
        @(negedge clk_96MHz);
        total_cnt++;
        if (overflow_count !== 8'd10 || fifo_level !== 3'd4)
            $display("FAIL sat_partial: got ovf=%0d level=%0d, required 10 4", overflow_count, fifo_level);
        else pass_cnt++;
        for (int k = 0; k < 300; k++) pulse(68'h5A);
        @(negedge clk_96MHz);
        total_cnt++;
        if (overflow_count !== 8'd255) $display("FAIL sat_count: got %0d, required 255", overflow_count);
        else pass_cnt++;
        total_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL sat_level: got %0d, required 4", fifo_level);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overflow();
        test_checksum();
        test_reset_mid();
        test_saturation();
        total_cnt++;
        if (framing_err != 0) $display("FAIL framing: got %0d bad stop bits, required 0", framing_err);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
